ch_model: RTL and testbench

CH_MODEL -- requirements
Module: ch_model

---
 rtl/ch_model_pkg.sv | 20 ++
 rtl/ch_model_mac.sv | 39 +++
 rtl/ch_model.sv | 119 +++++++++++
 tb/tb_ch_model.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ch_model_pkg.sv
// Purpose : shared types and width helper for the ch_model channel emulator.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum (IDLE/MAC/HOLD) and calc_w(), the full-precision
//           output width of a TAPS-term sum of N x M signed products.
package ch_model_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Bits needed so that TAPS products of N-bit by M-bit signed values never
    // overflow: N+M bits per product plus clog2(TAPS) bits of sum growth.
    function automatic int calc_w(input int n, input int m, input int taps);
        return n + m + $clog2(taps);
    endfunction

endpackage

// File: rtl/ch_model_mac.sv
// Purpose : signed multiply-accumulate, one coefficient x sample product per enabled cycle.
// Latency : product lands in acc on the enabling clock edge.
// Backpressure: none; caller gates en and pulses clr.
// Ports   : clk, rst_n (async active-low); clr zeroes acc (wins over en);
//           en adds coef*samp; acc is the W-bit signed running sum.
module ch_model_mac
    import ch_model_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int M    = 4,
    parameter  int TAPS = 4,
    localparam int W    = calc_w(N, M, TAPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic signed [M-1:0] coef,
    input  logic signed [N-1:0] samp,
    output logic signed [W-1:0] acc
);

    // Both operands are sign-extended to the product width before the
    // multiply, so the N+M-bit product is exact.
    logic signed [N+M-1:0] prod;

    assign prod = (N+M)'(coef) * (N+M)'(samp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + W'(prod);
        end
    end

endmodule

// File: rtl/ch_model.sv
// Purpose : forward channel model, out = sum_k coef[k]*x[n-k], one tap per cycle.
// Latency : out_valid rises TAPS+1 cycles after the accepting edge.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready.
// Ports   : clk, rst_n (async active-low); coef_wr/coef_addr/coef_data program
//           a tap (IDLE only); in_valid/in_ready/in_data sample input;
//           out_valid/out_ready/out_data result output; busy = MAC or HOLD.
module ch_model
    import ch_model_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int M    = 4,
    parameter  int TAPS = 4,
    localparam int AW   = $clog2(TAPS),
    localparam int W    = calc_w(N, M, TAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coef_wr,
    input  logic [AW-1:0] coef_addr,
    input  logic [M-1:0]  coef_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          busy
);

    // cnt walks 0..TAPS-1 while accumulating; the extra count TAPS is the
    // cycle that registers the finished sum into out_data.
    localparam int            CW     = $clog2(TAPS + 1);
    localparam logic [CW-1:0] LAST   = CW'(TAPS);
    localparam logic [AW:0]   TAPS_A = (AW+1)'(TAPS);

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;
    logic [AW-1:0]         tap;
    logic signed [M-1:0]   coef  [TAPS];
    logic signed [N-1:0]   dline [TAPS];
    logic signed [W-1:0]   acc;
    logic                  accept;
    logic                  mac_en;
    logic                  mac_done;
    logic                  coef_we;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;
    assign mac_en    = (state == MAC) && (cnt != LAST);
    assign mac_done  = (state == MAC) && (cnt == LAST);
    assign tap       = cnt[AW-1:0];
    // Writes outside IDLE are dropped so taps stay fixed for a computation.
    assign coef_we   = coef_wr && (state == IDLE) && ({1'b0, coef_addr} < TAPS_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = MAC;
            MAC:     if (mac_done)  state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            out_data <= '0;
            for (int i = 0; i < TAPS; i++) begin
                coef[i]  <= '0;
                dline[i] <= '0;
            end
        end else begin
            // A write coinciding with acceptance lands before MAC starts, so
            // the new tap already applies to the sample accepted this cycle.
            if (coef_we) begin
                coef[coef_addr] <= coef_data;
            end
            if (accept) begin
                dline[0] <= in_data;
                for (int i = 1; i < TAPS; i++) begin
                    dline[i] <= dline[i-1];
                end
                cnt <= '0;
            end else if (mac_en) begin
                cnt <= cnt + 1'b1;
            end
            if (mac_done) begin
                out_data <= acc;
            end
        end
    end

    ch_model_mac #(
        .N    (N),
        .M    (M),
        .TAPS (TAPS)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (mac_en),
        .coef  (coef[tap]),
        .samp  (dline[tap]),
        .acc   (acc)
    );

endmodule

// File: tb/tb_ch_model.sv
module tb_ch_model;

    localparam int N    = 8;
    localparam int M    = 4;
    localparam int TAPS = 4;
    localparam int W    = 14;

    logic         clk;
    logic         rst_n;
    logic         coef_wr;
    logic [1:0]   coef_addr;
    logic [M-1:0] coef_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state and scoreboard.
    logic signed [M-1:0] mcoef [TAPS];
    logic signed [N-1:0] mdl   [TAPS];
    logic signed [W-1:0] exp_q [$];

    ch_model #(.N(N), .M(M), .TAPS(TAPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coef_wr   (coef_wr),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            mcoef[i] = '0;
            mdl[i]   = '0;
        end
        exp_q.delete();
    endtask

    task automatic model_accept(input int x);
        int sum = 0;
        for (int i = TAPS - 1; i > 0; i--) mdl[i] = mdl[i-1];
        mdl[0] = N'(x);
        for (int k = 0; k < TAPS; k++) sum += int'(mcoef[k]) * int'(mdl[k]);
        exp_q.push_back(W'(sum));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        model_reset();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic coef_write(input int a, input int d);
        coef_wr   = 1'b1;
        coef_addr = 2'(a);
        coef_data = 4'(d);
        tick();
        coef_wr   = 1'b0;
        mcoef[a]  = 4'(d);
    endtask

    task automatic send(input int x);
        in_valid = 1'b1;
        in_data  = N'(x);
        tick();
        in_valid = 1'b0;
        model_accept(x);
    endtask

    // Cycles from the accepting edge until out_valid is seen; -1 on timeout.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            tick();
            if (out_valid) lat = i;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        #12;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL rst_out_data: got %0d want 0", out_data); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        coef_write(0, 1);
        send(9);
        tick();
        tick();
        n_total++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL midrst_out_data: got %0d want 0", out_data); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        model_reset();
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (out_valid) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL rst_no_pulse: got %0d valid cycles want 0", seen); else n_pass++;
    endtask

    task automatic test_identity();
        int lat;
        logic signed [W-1:0] e;
        do_reset();
        coef_write(0, 1);
        send(5);
        wait_out(lat);
        e = exp_q.pop_front();
        n_total++; if (lat !== 5) $display("FAIL id_latency: got %0d want 5", lat); else n_pass++;
        n_total++; if (out_data !== e) $display("FAIL id_model: got %0d want %0d", $signed(out_data), e); else n_pass++;
        n_total++; if (out_data !== 14'd5) $display("FAIL id_value: got %0d want 5", $signed(out_data)); else n_pass++;
        n_total++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL id_hold_flags: got rdy=%b busy=%b want 0/1", in_ready, busy); else n_pass++;
        drain();
        n_total++; if (out_valid !== 1'b0) $display("FAIL id_valid_drop: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_data !== e) $display("FAIL id_data_kept: got %0d want %0d", $signed(out_data), e); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL id_idle_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic run_pair(input string name, input int x0, input int x1, input int w0, input int w1);
        int lat;
        int xs [2];
        int ws [2];
        logic signed [W-1:0] e;
        xs[0] = x0; xs[1] = x1;
        ws[0] = w0; ws[1] = w1;
        for (int i = 0; i < 2; i++) begin
            send(xs[i]);
            wait_out(lat);
            e = exp_q.pop_front();
            n_total++; if (lat !== 5 || out_data !== e) $display("FAIL %s_model%0d: got %0d lat %0d want %0d lat 5", name, i, $signed(out_data), lat, e); else n_pass++;
            n_total++; if (out_data !== W'(ws[i])) $display("FAIL %s_value%0d: got %0d want %0d", name, i, $signed(out_data), ws[i]); else n_pass++;
            drain();
        end
    endtask

    task automatic test_delay();
        do_reset();
        coef_write(1, 1);
        run_pair("delay", 3, 7, 0, 3);
    endtask

    task automatic test_signed();
        do_reset();
        coef_write(0, 2);
        coef_write(1, -1);
        run_pair("signed", -4, 6, -8, 16);
    endtask

    task automatic test_worst();
        int lat;
        logic signed [W-1:0] e;
        do_reset();
        for (int k = 0; k < TAPS; k++) coef_write(k, -8);
        for (int i = 0; i < 4; i++) begin
            send(-128);
            wait_out(lat);
            e = exp_q.pop_front();
            n_total++; if (lat !== 5 || out_data !== e) $display("FAIL worst_model%0d: got %0d lat %0d want %0d", i, $signed(out_data), lat, e); else n_pass++;
            drain();
        end
        n_total++; if (out_data !== 14'd4096) $display("FAIL worst_value: got %0d want 4096", $signed(out_data)); else n_pass++;
    endtask

    task automatic test_backpressure();
        int lat;
        logic signed [W-1:0] e;
        do_reset();
        coef_write(0, 1);
        coef_write(1, 2);
        send(10);
        wait_out(lat);
        e = exp_q.pop_front();
        n_total++; if (lat !== 5 || out_data !== e) $display("FAIL bp_first: got %0d lat %0d want %0d", $signed(out_data), lat, e); else n_pass++;
        coef_wr   = 1'b1;
        coef_data = 4'd7;
        in_valid  = 1'b1;
        in_data   = 8'd99;
        for (int i = 0; i < 10; i++) begin
            coef_addr = 2'(i);
            tick();
            n_total++; if (out_data !== e) $display("FAIL bp_stable%0d: got %0d want %0d", i, $signed(out_data), e); else n_pass++;
            n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); else n_pass++;
            n_total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid%0d: got %b want 1", i, out_valid); else n_pass++;
        end
        coef_wr  = 1'b0;
        in_valid = 1'b0;
        drain();
        send(4);
        wait_out(lat);
        e = exp_q.pop_front();
        n_total++; if (lat !== 5 || out_data !== e) $display("FAIL bp_old_coef_model: got %0d lat %0d want %0d", $signed(out_data), lat, e); else n_pass++;
        n_total++; if (out_data !== 14'd24) $display("FAIL bp_old_coef_value: got %0d want 24", $signed(out_data)); else n_pass++;
        drain();
    endtask

    task automatic test_same_cycle();
        int lat;
        logic signed [W-1:0] e;
        do_reset();
        coef_wr   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 4'd3;
        in_valid  = 1'b1;
        in_data   = 8'd2;
        tick();
        coef_wr  = 1'b0;
        in_valid = 1'b0;
        mcoef[0] = 4'd3;
        model_accept(2);
        wait_out(lat);
        e = exp_q.pop_front();
        n_total++; if (lat !== 5 || out_data !== e) $display("FAIL same_cycle_model: got %0d lat %0d want %0d", $signed(out_data), lat, e); else n_pass++;
        n_total++; if (out_data !== 14'd6) $display("FAIL same_cycle_value: got %0d want 6", $signed(out_data)); else n_pass++;
        drain();
    endtask

    initial begin
        rst_n     = 1'b0;
        coef_wr   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        test_reset();
        test_identity();
        test_delay();
        test_signed();
        test_worst();
        test_backpressure();
        test_same_cycle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
